key_note_recorder: RTL and testbench

KEY_NOTE_RECORDER -- requirements
Module: key_note_recorder

---
 rtl/key_note_recorder_pkg.sv | 42 ++++
 rtl/key_sync_encoder.sv | 42 ++++
 rtl/key_note_recorder.sv | 197 +++++++++++++++++++
 tb/tb_key_note_recorder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/key_note_recorder_pkg.sv
// -----------------------------------------------------------------------------
// key_note_recorder_pkg
// Shared note vocabulary for the key recorder, doremi and led8 blocks:
// note codes, the recorder FSM state encoding, the count width and the
// key-to-note priority encoder.
// -----------------------------------------------------------------------------
package key_note_recorder_pkg;

    // Note codes as seen by the piezo/led8 path
    localparam logic [3:0] NOTE_DO      = 4'd1;
    localparam logic [3:0] NOTE_RE      = 4'd2;
    localparam logic [3:0] NOTE_MI      = 4'd3;
    localparam logic [3:0] NOTE_FA      = 4'd4;
    localparam logic [3:0] NOTE_SOL     = 4'd5;
    localparam logic [3:0] NOTE_LA      = 4'd6;
    localparam logic [3:0] NOTE_SI      = 4'd7;
    localparam logic [3:0] NOTE_HIGH_DO = 4'd8;
    localparam logic [3:0] NOTE_REST    = 4'd14;

    // Width of the stored-note counter and of the pointers (0..DEPTH)
    localparam int COUNT_W = 6;

    // Recorder FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REC  = 2'd1,
        ST_PLAY = 2'd2
    } rec_state_t;

    // Lowest pressed key wins: bit i gives code i+1; no key gives the rest code.
    // Scanning from the top bit down lets lower bits overwrite higher ones.
    function automatic logic [3:0] encode_key(input logic [7:0] keys,
                                              input logic [3:0] rest_code);
        logic [3:0] code;
        code = rest_code;
        for (int i = 7; i >= 0; i--) begin
            code = keys[i] ? 4'(i + 1) : code;
        end
        return code;
    endfunction

endpackage

// File: rtl/key_sync_encoder.sv
// -----------------------------------------------------------------------------
// key_sync_encoder
// Brings the raw push-button vector into the CLK domain through a 2-flop
// synchronizer and priority-encodes the synchronized value into a note code.
//
// Ports:
//   CLK     in   system clock
//   RESETN  in   asynchronous active-low reset
//   key     in   raw push buttons, bit i high = key i pressed
//   code    out  note code of the lowest pressed key (1..8), REST if none
// -----------------------------------------------------------------------------
module key_sync_encoder
    import key_note_recorder_pkg::*;
#(
    parameter logic [3:0] REST = 4'd14
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [7:0] key,
    output logic [3:0] code
);

    logic [7:0] key_meta_r;
    logic [7:0] key_sync_r;

    // Two-stage synchronizer; key_sync_r lags the pins by two clocks
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            key_meta_r <= 8'h00;
            key_sync_r <= 8'h00;
        end else begin
            key_meta_r <= key;
            key_sync_r <= key_meta_r;
        end
    end

    // Priority encoding of the synchronized keys
    always_comb begin
        code = encode_key(key_sync_r, REST);
    end

endmodule

// File: rtl/key_note_recorder.sv
// -----------------------------------------------------------------------------
// key_note_recorder
// Records the note played on the push buttons at every tempo tick into a
// DEPTH-slot memory and plays the sequence back one note per tick.
//
// Ports:
//   CLK       in   system clock, all state changes on its rising edge
//   RESETN    in   asynchronous active-low reset
//   tick      in   one-clock note-step strobe from the tempo counter
//   key       in   raw push buttons (synchronized internally)
//   rec       in   level request, rising edge starts recording
//   play      in   level request, rising edge starts playback
//   stop      in   level request, rising edge aborts recording/playback
//   note_out  out  registered note code to the piezo/led8 path
//   busy      out  high while recording or playing
//   full      out  high when the memory holds DEPTH notes
//   count     out  number of notes stored, 0..DEPTH
// -----------------------------------------------------------------------------
module key_note_recorder
    import key_note_recorder_pkg::*;
#(
    parameter int         DEPTH = 32,
    parameter logic [3:0] REST  = 4'd14
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic                tick,
    input  logic [7:0]          key,
    input  logic                rec,
    input  logic                play,
    input  logic                stop,
    output logic [3:0]          note_out,
    output logic                busy,
    output logic                full,
    output logic [COUNT_W-1:0]  count
);

    localparam int                 AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(DEPTH);
    localparam logic [COUNT_W-1:0] ZERO_C  = {COUNT_W{1'b0}};
    localparam logic [COUNT_W-1:0] ONE_C   = {{(COUNT_W-1){1'b0}}, 1'b1};

    rec_state_t          state_r, state_nx;
    logic [COUNT_W-1:0]  count_r, count_nx;
    logic [COUNT_W-1:0]  wr_ptr_r, wr_ptr_nx;
    logic [COUNT_W-1:0]  rd_ptr_r, rd_ptr_nx;
    logic [3:0]          note_r, note_nx;
    logic                busy_r;
    logic                full_r;
    logic                mem_we_s;
    logic [3:0]          mem_rd_s;
    logic [3:0]          code_s;
    logic [3:0]          mem_r [DEPTH];

    logic                rec_prev_r, play_prev_r, stop_prev_r;
    logic                rec_edge_s, play_edge_s, stop_edge_s;

    key_sync_encoder #(
        .REST (REST)
    ) u_key_sync_encoder (
        .CLK    (CLK),
        .RESETN (RESETN),
        .key    (key),
        .code   (code_s)
    );

    // Previous levels of the request inputs for rising-edge detection
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            rec_prev_r  <= 1'b0;
            play_prev_r <= 1'b0;
            stop_prev_r <= 1'b0;
        end else begin
            rec_prev_r  <= rec;
            play_prev_r <= play;
            stop_prev_r <= stop;
        end
    end

    // One-cycle rising-edge strobes
    always_comb begin
        rec_edge_s  = rec  & ~rec_prev_r;
        play_edge_s = play & ~play_prev_r;
        stop_edge_s = stop & ~stop_prev_r;
    end

    // Memory read port; only used while rd_ptr_r < count_r
    always_comb begin
        mem_rd_s = mem_r[rd_ptr_r[AW-1:0]];
    end

    // Next-state, pointer, counter and note computation
    always_comb begin
        state_nx  = state_r;
        count_nx  = count_r;
        wr_ptr_nx = wr_ptr_r;
        rd_ptr_nx = rd_ptr_r;
        note_nx   = note_r;
        mem_we_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                note_nx = REST;
                // rec has priority over a simultaneous play edge
                if (rec_edge_s) begin
                    count_nx  = ZERO_C;
                    wr_ptr_nx = ZERO_C;
                    state_nx  = ST_REC;
                end else if (play_edge_s && (count_r != ZERO_C)) begin
                    rd_ptr_nx = ZERO_C;
                    state_nx  = ST_PLAY;
                end else begin
                    state_nx  = ST_IDLE;
                end
            end
            ST_REC: begin
                note_nx = REST;
                // stop beats a coincident tick: nothing is written
                if (stop_edge_s) begin
                    state_nx = ST_IDLE;
                end else if (tick) begin
                    mem_we_s  = 1'b1;
                    wr_ptr_nx = wr_ptr_r + ONE_C;
                    count_nx  = count_r + ONE_C;
                    // the write that fills the memory ends recording at once
                    if ((count_r + ONE_C) == DEPTH_C) begin
                        state_nx = ST_IDLE;
                    end else begin
                        state_nx = ST_REC;
                    end
                end else begin
                    state_nx = ST_REC;
                end
            end
            ST_PLAY: begin
                if (stop_edge_s) begin
                    note_nx  = REST;
                    state_nx = ST_IDLE;
                end else if (tick) begin
                    if (rd_ptr_r == count_r) begin
                        note_nx  = REST;
                        state_nx = ST_IDLE;
                    end else begin
                        note_nx   = mem_rd_s;
                        rd_ptr_nx = rd_ptr_r + ONE_C;
                    end
                end else begin
                    state_nx = ST_PLAY;
                end
            end
            default: begin
                note_nx  = REST;
                state_nx = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Datapath registers and registered status outputs
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            count_r  <= ZERO_C;
            wr_ptr_r <= ZERO_C;
            rd_ptr_r <= ZERO_C;
            note_r   <= REST;
            busy_r   <= 1'b0;
            full_r   <= 1'b0;
        end else begin
            count_r  <= count_nx;
            wr_ptr_r <= wr_ptr_nx;
            rd_ptr_r <= rd_ptr_nx;
            note_r   <= note_nx;
            busy_r   <= (state_nx != ST_IDLE);
            full_r   <= (count_nx == DEPTH_C);
        end
    end

    // Note memory; deliberately not reset so recordings survive aborts
    always_ff @(posedge CLK) begin
        if (mem_we_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= code_s;
        end
    end

    assign note_out = note_r;
    assign busy     = busy_r;
    assign full     = full_r;
    assign count    = count_r;

endmodule

// File: tb/tb_key_note_recorder.sv
// -----------------------------------------------------------------------------
// tb_key_note_recorder
// Self-checking bench: a small behavioural model tracks what was recorded,
// expected playback notes are queued when a play tick is driven and compared
// against note_out once the DUT has registered it.
// -----------------------------------------------------------------------------
module tb_key_note_recorder;

    localparam int         DEPTH = 32;
    localparam logic [3:0] REST  = 4'd14;

    logic       CLK = 1'b0;
    logic       RESETN;
    logic       tick;
    logic [7:0] key;
    logic       rec;
    logic       play;
    logic       stop;
    logic [3:0] note_out;
    logic       busy;
    logic       full;
    logic [5:0] count;

    int checks   = 0;
    int failures = 0;

    // reference model
    logic [3:0] m_mem [DEPTH];
    int         m_cnt;
    int         m_rd;
    int         m_state;          // 0 idle, 1 rec, 2 play
    logic [3:0] exp_q [$];

    key_note_recorder #(
        .DEPTH (DEPTH),
        .REST  (REST)
    ) dut (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .tick     (tick),
        .key      (key),
        .rec      (rec),
        .play     (play),
        .stop     (stop),
        .note_out (note_out),
        .busy     (busy),
        .full     (full),
        .count    (count)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_code(input logic [7:0] k);
        for (int i = 0; i < 8; i++) begin
            if (k[i]) return 4'(i + 1);
        end
        return REST;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic check_status(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'(m_state != 0));
        check_eq({tag, "_count"}, 32'(count), 32'(m_cnt));
        check_eq({tag, "_full"}, 32'(full), 32'(m_cnt == DEPTH));
    endtask

    task automatic pulse_rec();
        rec = 1'b1; cyc(1); rec = 1'b0; cyc(1);
        if (m_state == 0) begin
            m_cnt   = 0;
            m_state = 1;
        end
        check_status("rec_edge");
        check_eq("rec_note", 32'(note_out), 32'(REST));
    endtask

    task automatic pulse_play();
        play = 1'b1; cyc(1); play = 1'b0; cyc(1);
        if (m_state == 0 && m_cnt > 0) begin
            m_rd    = 0;
            m_state = 2;
        end
        check_status("play_edge");
    endtask

    task automatic pulse_stop();
        stop = 1'b1; cyc(1); stop = 1'b0; cyc(1);
        m_state = 0;
        check_status("stop_edge");
        check_eq("stop_note", 32'(note_out), 32'(REST));
    endtask

    // present a key long enough to pass the synchronizer, then tick once
    task automatic rec_tick(input logic [7:0] k);
        key = k;
        cyc(3);
        tick = 1'b1; cyc(1); tick = 1'b0;
        if (m_state == 1) begin
            m_mem[m_cnt] = ref_code(k);
            m_cnt++;
            if (m_cnt == DEPTH) m_state = 0;
        end
        check_status("rec_tick");
        check_eq("rec_tick_note", 32'(note_out), 32'(REST));
    endtask

    task automatic play_tick();
        logic [3:0] exp;
        tick = 1'b1;
        if (m_state != 2) begin
            exp_q.push_back(REST);
        end else if (m_rd == m_cnt) begin
            exp_q.push_back(REST);
            m_state = 0;
        end else begin
            exp_q.push_back(m_mem[m_rd]);
            m_rd++;
        end
        cyc(1);
        tick = 1'b0;
        exp = exp_q.pop_front();
        check_eq("play_note", 32'(note_out), 32'(exp));
        check_eq("play_busy", 32'(busy), 32'(m_state != 0));
    endtask

    initial begin
        RESETN = 1'b0; tick = 1'b0; key = 8'h00; rec = 1'b0; play = 1'b0; stop = 1'b0;
        m_cnt = 0; m_rd = 0; m_state = 0;
        cyc(3);
        // reset values
        check_eq("rst_note", 32'(note_out), 32'(REST));
        check_status("rst");
        RESETN = 1'b1;
        cyc(2);

        // play with nothing recorded is ignored
        pulse_play();

        // basic record / play sequence
        pulse_rec();
        rec_tick(8'h01);
        rec_tick(8'h04);
        rec_tick(8'h00);
        pulse_stop();
        check_eq("basic_count", 32'(count), 32'd3);
        pulse_play();
        for (int i = 0; i < 4; i++) play_tick();
        check_eq("basic_end_busy", 32'(busy), 32'd0);

        // replay gives the same sequence
        pulse_play();
        for (int i = 0; i < 4; i++) play_tick();

        // lowest key wins, random keys, requests while busy ignored
        pulse_rec();
        rec_tick(8'h0C);
        pulse_play();
        pulse_rec();
        for (int i = 0; i < 5; i++) rec_tick(8'($urandom_range(0, 255)));
        pulse_stop();
        pulse_play();
        pulse_rec();
        for (int i = 0; i < 7; i++) play_tick();
        check_eq("lowbit_first", 32'(m_mem[0]), 32'd3);

        // stop coincident with a tick in PLAY at rd_ptr=1
        pulse_play();
        play_tick();
        stop = 1'b1; tick = 1'b1; cyc(1); stop = 1'b0; tick = 1'b0;
        m_state = 0;
        check_eq("stoptick_note", 32'(note_out), 32'(REST));
        check_status("stoptick");
        cyc(1);
        pulse_play();
        for (int i = 0; i < 7; i++) play_tick();

        // fill the memory
        pulse_rec();
        for (int i = 0; i < DEPTH; i++) rec_tick(8'h80);
        check_eq("full_flag", 32'(full), 32'd1);
        check_eq("full_busy", 32'(busy), 32'd0);
        rec_tick(8'h80);
        check_eq("full_count", 32'(count), 32'd32);
        pulse_play();
        for (int i = 0; i < DEPTH + 1; i++) play_tick();

        // asynchronous reset during playback
        pulse_play();
        play_tick();
        play_tick();
        check_eq("pre_rst_note", 32'(note_out), 32'd8);
        #2;
        RESETN = 1'b0;
        #1;
        m_state = 0; m_cnt = 0;
        check_eq("async_rst_note", 32'(note_out), 32'(REST));
        check_status("async_rst");
        cyc(2);
        RESETN = 1'b1;
        cyc(2);
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
